// File: rtl/tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tt_sweep_ctrl
//
// Stimulus/capture controller for a 3-input gate-logic block. On an accepted
// start it drives {a,b,c} through vectors 0..7, holding each for DWELL
// cycles. At the last cycle of each dwell it samples the block's x,y
// responses, then packs all 8 response pairs into a 16-bit result word.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   sweep request, level-sampled in IDLE only
//   abc_out  out  3   {a,b,c} to the downstream block (a is the MSB)
//   x_in     in   1   x response from the downstream block
//   y_in     in   1   y response from the downstream block
//   busy     out  1   high while a sweep is in progress (DRIVE or FINISH)
//   done     out  1   one-cycle pulse when a sweep completes
//   valid    out  1   high from sweep completion until the next accepted start
//   result   out  16  result[2i+1]=x, result[2i]=y captured for vector i
//
// All outputs are registered. x_in/y_in are treated as combinational
// responses to abc_out and must settle within DWELL cycles; there is no
// synchroniser on them.
// ---------------------------------------------------------------------------
module tt_sweep_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [2:0]  abc_out,
    input  logic        x_in,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [15:0] result
);

    // Reject parameter sets the dwell counter cannot represent.
    if (DWELL < 1 || DWELL > 255 || (2 ** CW) <= DWELL) begin : g_bad_param
        $error("tt_sweep_ctrl: DWELL must be 1..255 and below 2**CW");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t        r_state;
    logic [2:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_abc;
    logic          r_busy;
    logic          r_done;
    logic          r_valid;
    logic [15:0]   r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset also aborts a sweep in progress, without a done pulse.
            r_state  <= S_IDLE;
            r_vec    <= 3'd0;
            r_cnt    <= '0;
            r_abc    <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abc  <= 3'd0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_state  <= S_DRIVE;
                        r_vec    <= 3'd0;
                        r_cnt    <= '0;
                        r_result <= 16'h0000;
                        r_valid  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                S_DRIVE: begin
                    if (r_cnt == CNT_LAST) begin
                        // End of dwell: x,y have settled for the current vector.
                        r_result[{r_vec, 1'b0} +: 2] <= {x_in, y_in};
                        r_cnt <= '0;
                        if (r_vec == 3'd7) begin
                            r_state <= S_FINISH;
                            r_abc   <= 3'd0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            // abc_out moves in the same edge as vec so the
                            // new vector is held for a full DWELL cycles.
                            r_vec <= r_vec + 3'd1;
                            r_abc <= r_vec + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_abc   <= 3'd0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_abc   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign abc_out = r_abc;
    assign busy    = r_busy;
    assign done    = r_done;
    assign valid   = r_valid;
    assign result  = r_result;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tt_sweep_ctrl
//
// Two instances: one with DWELL=4 driving a behavioural gate block
// (x=~c^(a&b), y=a&b, or a random truth table), and one with DWELL=1 whose
// x/y inputs are tied to 1/0.
// ---------------------------------------------------------------------------
module tb_tt_sweep_ctrl;

    localparam int D4 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [2:0]  abc4;
    logic        x4, y4;
    logic        busy4, done4, valid4;
    logic [15:0] result4;

    logic        start1 = 1'b0;
    logic [2:0]  abc1;
    logic        x1, y1;
    logic        busy1, done1, valid1;
    logic [15:0] result1;

    int checks   = 0;
    int failures = 0;
    int done_cnt4 = 0;
    int done_cnt1 = 0;

    // Downstream block model: mode 0 = lab gate function, mode 1 = random LUT.
    int         mode  = 0;
    logic [7:0] lut_x = 8'h00;
    logic [7:0] lut_y = 8'h00;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.DWELL(D4), .CW(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abc_out(abc4),
        .x_in(x4), .y_in(y4), .busy(busy4), .done(done4),
        .valid(valid4), .result(result4)
    );

    tt_sweep_ctrl #(.DWELL(D1), .CW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abc_out(abc1),
        .x_in(x1), .y_in(y1), .busy(busy1), .done(done1),
        .valid(valid1), .result(result1)
    );

    function automatic logic gate_x(input int m, input logic [2:0] v);
        if (m == 0) return ~v[0] ^ (v[2] & v[1]);
        return lut_x[v];
    endfunction

    function automatic logic gate_y(input int m, input logic [2:0] v);
        if (m == 0) return v[2] & v[1];
        return lut_y[v];
    endfunction

    always_comb begin
        x4 = gate_x(mode, abc4);
        y4 = gate_y(mode, abc4);
    end

    assign x1 = 1'b1;
    assign y1 = 1'b0;

    always @(posedge clk) begin
        if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    // Expected full result word for the current downstream model.
    function automatic logic [15:0] model_result(input int m);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[2*i+1] = gate_x(m, 3'(i));
            r[2*i]   = gate_y(m, 3'(i));
        end
        return r;
    endfunction

    // Bits of the result that have been captured after n vectors.
    function automatic logic [15:0] captured_mask(input int n);
        logic [15:0] m;
        m = 16'h0000;
        for (int k = 0; k < n; k++) m[2*k +: 2] = 2'b11;
        return m;
    endfunction

    // One full sweep on dut4. Called at a negedge; returns at the negedge
    // in the IDLE cycle following FINISH. start is held when hold=1 and
    // re-pulsed once at cycle pulse_j (to show it is ignored mid-sweep).
    task automatic run_sweep4(input logic [15:0] exp, input int pulse_j,
                              input bit hold, input string tag);
        logic [21:0] obs, req;
        int dc0;
        int nvec;
        start4 = 1'b1;
        @(posedge clk);                       // edge T: acceptance
        dc0 = done_cnt4;
        for (int j = 0; j < 8 * D4; j++) begin
            @(negedge clk);                   // after edge T+j
            nvec = j / D4;
            obs = {abc4, busy4, done4, valid4, result4};
            req = {3'(nvec), 1'b1, 1'b0, 1'b0, exp & captured_mask(nvec)};
            checks++;
            if (obs !== req) begin
                failures++;
                $display("FAIL %s drive j=%0d {abc,busy,done,valid,result}: got %h required %h",
                         tag, j, obs, req);
            end
            start4 = hold || (j == pulse_j);
        end
        @(negedge clk);                       // FINISH cycle, after edge T+8*D
        obs = {abc4, busy4, done4, valid4, result4};
        req = {3'd0, 1'b1, 1'b1, 1'b1, exp};
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s finish {abc,busy,done,valid,result}: got %h required %h",
                     tag, obs, req);
        end
        start4 = hold;
        @(negedge clk);                       // IDLE cycle
        obs = {abc4, busy4, done4, valid4, result4};
        req = {3'd0, 1'b0, 1'b0, 1'b1, exp};
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s idle {abc,busy,done,valid,result}: got %h required %h",
                     tag, obs, req);
        end
        checks++;
        if (done_cnt4 !== dc0 + 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d required %0d", tag, done_cnt4 - dc0, 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({abc4, busy4, done4, valid4, result4} !== 22'd0) begin
            failures++;
            $display("FAIL reset_dut4: got %h required %h",
                     {abc4, busy4, done4, valid4, result4}, 22'd0);
        end
        checks++;
        if ({abc1, busy1, done1, valid1, result1} !== 22'd0) begin
            failures++;
            $display("FAIL reset_dut1: got %h required %h",
                     {abc1, busy1, done1, valid1, result1}, 22'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, valid4} !== 3'b000) begin
            failures++;
            $display("FAIL idle_no_start: got %b required %b", {busy4, done4, valid4}, 3'b000);
        end
    endtask

    task automatic test_basic_sweep();
        mode = 0;
        checks++;
        if (model_result(0) !== 16'hD222) begin
            failures++;
            $display("FAIL model_sanity: got %h required %h", model_result(0), 16'hD222);
        end
        run_sweep4(16'hD222, -1, 1'b0, "basic");
    endtask

    task automatic test_dwell1();
        logic [21:0] obs, req;
        int dc0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        dc0 = done_cnt1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            start1 = 1'b0;
            obs = {abc1, busy1, done1, valid1, result1};
            req = {3'(j), 1'b1, 1'b0, 1'b0, 16'hAAAA & captured_mask(j)};
            checks++;
            if (obs !== req) begin
                failures++;
                $display("FAIL dwell1 j=%0d {abc,busy,done,valid,result}: got %h required %h",
                         j, obs, req);
            end
        end
        @(negedge clk);
        obs = {abc1, busy1, done1, valid1, result1};
        req = {3'd0, 1'b1, 1'b1, 1'b1, 16'hAAAA};
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL dwell1 finish: got %h required %h", obs, req);
        end
        @(negedge clk);
        obs = {abc1, busy1, done1, valid1, result1};
        req = {3'd0, 1'b0, 1'b0, 1'b1, 16'hAAAA};
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL dwell1 idle: got %h required %h", obs, req);
        end
        checks++;
        if (done_cnt1 !== dc0 + 1) begin
            failures++;
            $display("FAIL dwell1 done_pulses: got %0d required %0d", done_cnt1 - dc0, 1);
        end
    endtask

    task automatic test_reset_mid();
        int dc0;
        mode = 0;
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (3 * D4) @(negedge clk);       // after edge T+3*D: vector 3
        checks++;
        if (abc4 !== 3'd3) begin
            failures++;
            $display("FAIL reset_mid pre abc: got %0d required %0d", abc4, 3);
        end
        dc0 = done_cnt4;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({abc4, busy4, done4, valid4, result4} !== 22'd0) begin
            failures++;
            $display("FAIL reset_mid post: got %h required %h",
                     {abc4, busy4, done4, valid4, result4}, 22'd0);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt4 !== dc0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid aborted: done pulses %0d busy %b required 0 and 0",
                     done_cnt4 - dc0, busy4);
        end
        run_sweep4(16'hD222, -1, 1'b0, "after_reset");
    endtask

    task automatic test_start_ignored();
        mode = 0;
        repeat (2) @(negedge clk);
        run_sweep4(16'hD222, 5 * D4 + 1, 1'b0, "start_in_drive");
    endtask

    task automatic test_back_to_back();
        mode = 0;
        repeat (2) @(negedge clk);
        run_sweep4(16'hD222, -1, 1'b1, "b2b_1");
        run_sweep4(16'hD222, -1, 1'b1, "b2b_2");
        run_sweep4(16'hD222, -1, 1'b0, "b2b_3");
    endtask

    task automatic test_idle_hold();
        int bad;
        bad = 0;
        start4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({abc4, busy4, done4, valid4, result4} !== {3'd0, 1'b0, 1'b0, 1'b1, 16'hD222}) begin
                failures++;
                $display("FAIL idle_hold i=%0d: got %h required %h", i,
                         {abc4, busy4, done4, valid4, result4},
                         {3'd0, 1'b0, 1'b0, 1'b1, 16'hD222});
            end
        end
    endtask

    task automatic test_random_lut();
        logic [15:0] exp;
        for (int n = 0; n < 4; n++) begin
            mode  = 1;
            lut_x = 8'($urandom);
            lut_y = 8'($urandom);
            exp   = model_result(1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep4(exp, int'($urandom_range(0, 8 * D4 - 1)), 1'b0, "random_lut");
        end
        mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_sweep();
        test_dwell1();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_idle_hold();
        test_random_lut();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Stimulus/capture stage placed directly upstream of the lab's 3-input gate-logic blocks.
- Drives the block's a,b,c inputs through all 8 combinations and holds each for a set dwell time.
- Samples the block's x,y outputs at the end of each dwell and packs all 16 response bits into one result word for LEDs or a checker.
- Runs on a start/busy/done handshake.

Parameters:
- DWELL, 4, clock cycles each input vector is held before x,y are sampled; legal range 1..255.
- CW, 8, width of the dwell counter; must satisfy 2^CW > DWELL.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  sweep request; level-sampled in IDLE only.
- abc_out  out  3  {a,b,c} driven to the downstream block; a is the MSB.
- x_in  in  1  x response from the downstream block.
- y_in  in  1  y response from the downstream block.
- busy  out  1  high while a sweep is in progress (DRIVE or FINISH).
- done  out  1  one-cycle pulse when a sweep completes.
- valid  out  1  high from sweep completion until the next accepted start.
- result  out  16  result[2i+1]=x, result[2i]=y captured for vector i (abc_out==i).

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). All outputs are registered.
- Reset, or rst_n low at any edge including mid-sweep:
  - state=IDLE; abc_out=3'b000; busy=0; done=0; valid=0; result=16'h0000.
  - vec=0; cnt=0.
  - An aborted sweep produces no done pulse.
- States: IDLE, DRIVE, FINISH.
- IDLE:
  - abc_out=000, busy=0, done=0.
  - On an edge with start=1: go to DRIVE; vec=0, cnt=0, result=0, valid=0, busy=1.
- DRIVE:
  - abc_out=vec, held stable for exactly DWELL cycles.
  - cnt increments each edge.
  - At the edge where cnt==DWELL-1: result[2vec+1:2vec] <= {x_in,y_in}; cnt=0.
  - If vec==7, go to FINISH at that edge; otherwise vec=vec+1.
  - vec never wraps inside a sweep.
- FINISH:
  - Lasts one cycle: done=1, valid=1, busy=1, abc_out=000.
  - Next edge: IDLE, done=0, busy=0. valid and result hold.
- start is ignored in DRIVE and FINISH; it is not queued.
- If start is still high in IDLE (the cycle after FINISH), a new sweep begins immediately. result and valid clear on that acceptance.
- Latency, with start sampled at edge T:
  - abc_out=000 and busy=1 from T+1.
  - First capture at edge T+DWELL.
  - Last capture at edge T+8·DWELL.
  - done high in the cycle after edge T+8·DWELL.
  - busy falls at T+8·DWELL+2.
- x_in/y_in are treated as combinational responses to abc_out. The downstream block must settle within DWELL cycles; no synchroniser is included.
- DWELL=1 is legal: each vector is driven one cycle and sampled at the end of that cycle.

Test Plan:
1. DWELL=4; bench model x=~c^(a&b), y=a&b on abc_out; pulse start one cycle.
   - abc_out steps 0..7, 4 cycles each.
   - done pulses once, 33 cycles after the start edge.
   - result=16'hD222; valid=1 afterwards.
2. DWELL=1; x_in tied 1, y_in tied 0; start pulse.
   - abc_out changes every cycle.
   - done 9 cycles after the start edge; result=16'hAAAA.
3. Reset mid-sweep (rst_n low at vec=3 for one edge), model from test 1.
   - Next cycle: abc_out=000, busy=0, result=0, valid=0.
   - No done pulse appears.
   - A fresh start then yields 16'hD222.
4. Start pulsed again during DRIVE (vec=5).
   - Ignored: sweep timing is unchanged and exactly one done pulse occurs.
5. start held high continuously.
   - Sweeps repeat back-to-back with one IDLE cycle between FINISH and the next DRIVE.
   - valid drops at each re-acceptance; result clears to 0, then rebuilds to 16'hD222.
6. After a completed sweep, start=0 for 20 cycles.
   - valid=1, result stable, busy=0, done=0 throughout.
